// File: rtl/sensor_pkg.sv
// Shared channel encodings and data widths for the sensor front-end averager.
package sensor_pkg;

  typedef enum logic [1:0] {
    CH_TEMP    = 2'd0,
    CH_LIGHT   = 2'd1,
    CH_POWER   = 2'd2,
    CH_ILLEGAL = 2'd3
  } sensor_chan_e;

  localparam int TEMP_W  = 8;
  localparam int LIGHT_W = 8;
  localparam int POWER_W = 9;

endpackage

// File: rtl/sensor_avg_channel.sv
// One averaging lane: windowed accumulator, held output register, update pulse
// and staleness timer.
module sensor_avg_channel #(
  parameter int DATA_W   = 8,
  parameter int LOG2_AVG = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] avg,
  output logic              upd,
  output logic              stale
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [LOG2_AVG-1:0] LAST_IDX = '1;
  localparam logic [TO_W-1:0]     TO_MAX   = TO_W'(TIMEOUT);

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [LOG2_AVG-1:0] count;
  logic [TO_W-1:0]     to_cnt;
  logic                done;

  assign sum  = acc + ACC_W'(sample_data);
  assign done = sample_en && (count == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      avg   <= '0;
      upd   <= 1'b0;
    end else begin
      upd <= done;
      if (sample_en) begin
        if (done) begin
          avg   <= sum[ACC_W-1:LOG2_AVG];
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= sum;
          count <= count + LOG2_AVG'(1);
        end
      end
    end
  end

  // Stale stays set from reset until the first completed window, then
  // re-arms whenever the counter saturates; a completion always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      stale  <= 1'b1;
    end else if (done) begin
      to_cnt <= '0;
      stale  <= 1'b0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
      if ((to_cnt + TO_W'(1)) == TO_MAX) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_frontend_averager.sv
// Sensor sample front end: handshake, channel decode, illegal-channel flag and
// three averaging lanes feeding the threshold controller.
module sensor_frontend_averager
  import sensor_pkg::*;
#(
  parameter int LOG2_AVG = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [1:0]         sample_chan,
  input  logic [8:0]         sample_data,
  input  logic               freeze,
  output logic [TEMP_W-1:0]  temperature_sensor,
  output logic [LIGHT_W-1:0] light_sensor,
  output logic [POWER_W-1:0] power_monitor,
  output logic [2:0]         upd,
  output logic [2:0]         stale,
  output logic               chan_err
);

  logic accept;
  logic temp_en;
  logic light_en;
  logic power_en;

  assign accept   = sample_valid && sample_ready;
  assign temp_en  = accept && (sample_chan == CH_TEMP);
  assign light_en = accept && (sample_chan == CH_LIGHT);
  assign power_en = accept && (sample_chan == CH_POWER);

  // Ready lags freeze by one cycle so it is a clean registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_ready <= 1'b0;
      chan_err     <= 1'b0;
    end else begin
      sample_ready <= !freeze;
      if (accept && (sample_chan == CH_ILLEGAL)) begin
        chan_err <= 1'b1;
      end
    end
  end

  sensor_avg_channel #(
    .DATA_W   (TEMP_W),
    .LOG2_AVG (LOG2_AVG),
    .TIMEOUT  (TIMEOUT)
  ) u_temp (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (temp_en),
    .sample_data (sample_data[TEMP_W-1:0]),
    .avg         (temperature_sensor),
    .upd         (upd[0]),
    .stale       (stale[0])
  );

  sensor_avg_channel #(
    .DATA_W   (LIGHT_W),
    .LOG2_AVG (LOG2_AVG),
    .TIMEOUT  (TIMEOUT)
  ) u_light (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (light_en),
    .sample_data (sample_data[LIGHT_W-1:0]),
    .avg         (light_sensor),
    .upd         (upd[1]),
    .stale       (stale[1])
  );

  sensor_avg_channel #(
    .DATA_W   (POWER_W),
    .LOG2_AVG (LOG2_AVG),
    .TIMEOUT  (TIMEOUT)
  ) u_power (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (power_en),
    .sample_data (sample_data[POWER_W-1:0]),
    .avg         (power_monitor),
    .upd         (upd[2]),
    .stale       (stale[2])
  );

endmodule

// File: tb/tb_sensor_frontend_averager.sv
// Randomized plus directed bench for sensor_frontend_averager, checked every
// cycle against a window/timeout reference model.
module tb_sensor_frontend_averager;

  localparam int WIN = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic       sample_ready;
  logic [1:0] sample_chan;
  logic [8:0] sample_data;
  logic       freeze;
  logic [7:0] temperature_sensor;
  logic [7:0] light_sensor;
  logic [8:0] power_monitor;
  logic [2:0] upd;
  logic [2:0] stale;
  logic       chan_err;

  int checks   = 0;
  int failures = 0;

  int win_samples [3][$];
  int exp_out [3];
  bit exp_upd [3];
  int since   [3];
  bit seen    [3];
  bit exp_ready;
  bit exp_err;
  bit pend;

  sensor_frontend_averager #(
    .LOG2_AVG (2),
    .TIMEOUT  (TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sample_valid       (sample_valid),
    .sample_ready       (sample_ready),
    .sample_chan        (sample_chan),
    .sample_data        (sample_data),
    .freeze             (freeze),
    .temperature_sensor (temperature_sensor),
    .light_sensor       (light_sensor),
    .power_monitor      (power_monitor),
    .upd                (upd),
    .stale              (stale),
    .chan_err           (chan_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      win_samples[c].delete();
      exp_out[c] = 0;
      exp_upd[c] = 0;
      since[c]   = 0;
      seen[c]    = 0;
    end
    exp_ready = 0;
    exp_err   = 0;
    pend      = 0;
  endtask

  // Apply one clock edge worth of spec behaviour to the model.
  task automatic modelEdge();
    bit accepted;
    bit refreshed [3];
    int c;
    int total;
    accepted = sample_valid && exp_ready;
    pend     = sample_valid && !exp_ready;
    for (int k = 0; k < 3; k++) begin
      exp_upd[k]   = 0;
      refreshed[k] = 0;
    end
    if (accepted) begin
      if (sample_chan == 2'd3) begin
        exp_err = 1;
      end else begin
        c = int'(sample_chan);
        win_samples[c].push_back((c == 2) ? int'(sample_data) : int'(sample_data) % 256);
        if (win_samples[c].size() == WIN) begin
          total = 0;
          foreach (win_samples[c][k]) total += win_samples[c][k];
          exp_out[c] = total / WIN;
          win_samples[c].delete();
          exp_upd[c]   = 1;
          refreshed[c] = 1;
          since[c]     = 0;
          seen[c]      = 1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!refreshed[k] && since[k] < TO) since[k]++;
    end
    exp_ready = !freeze;
  endtask

  task automatic compareAll();
    logic [2:0] u;
    logic [2:0] s;
    for (int k = 0; k < 3; k++) begin
      u[k] = exp_upd[k];
      s[k] = !seen[k] || (since[k] >= TO);
    end
    checkOutput("sample_ready", 32'(sample_ready), 32'(exp_ready));
    checkOutput("temperature", 32'(temperature_sensor), exp_out[0]);
    checkOutput("light", 32'(light_sensor), exp_out[1]);
    checkOutput("power", 32'(power_monitor), exp_out[2]);
    checkOutput("upd", 32'(upd), 32'(u));
    checkOutput("stale", 32'(stale), 32'(s));
    checkOutput("chan_err", 32'(chan_err), 32'(exp_err));
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] ch, input logic [8:0] d, input bit f);
    @(negedge clk);
    sample_valid = v;
    sample_chan  = ch;
    sample_data  = d;
    freeze       = f;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst          = 1'b1;
    sample_valid = 1'b0;
    freeze       = 1'b0;
    modelReset();
    #1;
    compareAll();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 9'd0, 1'b0);
  endtask

  initial begin
    bit         v;
    bit         f;
    logic [1:0] ch;
    logic [8:0] d;

    rst          = 1'b0;
    sample_valid = 1'b0;
    sample_chan  = 2'd0;
    sample_data  = 9'd0;
    freeze       = 1'b0;
    modelReset();

    doReset(3);
    checkOutput("reset_stale", 32'(stale), 32'd7);
    idle(1);
    checkOutput("ready_after_release", 32'(sample_ready), 32'd1);

    applyStimulus(1'b1, 2'd0, 9'd30, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd32, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd34, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd36, 1'b0);
    checkOutput("temp_avg_33", 32'(temperature_sensor), 32'd33);
    checkOutput("temp_upd_pulse", 32'(upd), 32'd1);
    idle(1);
    checkOutput("temp_upd_cleared", 32'(upd), 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd2, 9'd511, 1'b0);
    checkOutput("power_full_scale", 32'(power_monitor), 32'd511);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 9'h1FF, 1'b0);
    checkOutput("light_bit8_dropped", 32'(light_sensor), 32'd255);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd0, 9'd10, 1'b0);
      applyStimulus(1'b1, 2'd1, 9'd20, 1'b0);
      applyStimulus(1'b1, 2'd2, 9'(100 + 20 * i), 1'b0);
    end
    checkOutput("interleave_power", 32'(power_monitor), 32'd130);

    applyStimulus(1'b1, 2'd3, 9'd5, 1'b0);
    checkOutput("chan_err_set", 32'(chan_err), 32'd1);
    idle(3);

    applyStimulus(1'b1, 2'd0, 9'd8, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd8, 1'b0);
    applyStimulus(1'b0, 2'd0, 9'd8, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 9'd8, 1'b1);
    checkOutput("frozen_ready", 32'(sample_ready), 32'd0);
    applyStimulus(1'b1, 2'd0, 9'd8, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd8, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd8, 1'b0);
    checkOutput("resume_after_freeze", 32'(temperature_sensor), 32'd8);
    idle(TO);
    checkOutput("temp_goes_stale", 32'(stale[0]), 32'd1);

    applyStimulus(1'b1, 2'd0, 9'd200, 1'b0);
    applyStimulus(1'b1, 2'd0, 9'd200, 1'b0);
    doReset(2);
    checkOutput("chan_err_cleared", 32'(chan_err), 32'd0);
    idle(1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 9'd4, 1'b0);
    checkOutput("partial_discarded", 32'(temperature_sensor), 32'd4);

    // Random traffic; a stalled sample is held stable until it is taken.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        doReset(1);
      end
      f = ($urandom_range(0, 9) == 0);
      if (!pend) begin
        v  = ($urandom_range(0, 3) != 0) && (i % 200 < 150);
        ch = ($urandom_range(0, 49) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        d  = 9'($urandom_range(0, 511));
      end
      applyStimulus(v, ch, d, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
